// File: rtl/sipo_rx.sv
// Serial-in / parallel-out receiver.
// Frames a qualified bit stream into WIDTH-bit words with a one-cycle valid strobe.
module sipo_rx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             si,
    input  logic             sen,
    input  logic             sof,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             busy,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first;

    // A new frame starts from an empty register so stale bits never leak into q.
    always_comb begin
        shifted = '0;
        first   = '0;
        if (LSB_FIRST) begin
            shifted = {si, sr[WIDTH-1:1]};
            first   = {si, {(WIDTH-1){1'b0}}};
        end else begin
            shifted = {sr[WIDTH-2:0], si};
            first   = {{(WIDTH-1){1'b0}}, si};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            q     <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (clr_err)
                err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sen && sof) begin
                        sr    <= first;
                        cnt   <= CW'(1);
                        state <= RECV;
                        busy  <= 1'b1;
                    end
                end
                RECV: begin
                    if (sen) begin
                        if (sof) begin
                            err <= 1'b1;
                            sr  <= first;
                            cnt <= CW'(1);
                        end else if (cnt == LAST) begin
                            sr    <= shifted;
                            q     <= shifted;
                            valid <= 1'b1;
                            cnt   <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            sr  <= shifted;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: LSB- and MSB-first instances share one stimulus stream.
// A frame-level reference model predicts words; a negedge monitor compares.
module tb_sipo_rx;

    logic       clk = 1'b0;
    logic       rst_n, si, sen, sof, clr_err;
    logic [7:0] q0, q1;
    logic       v0, v1, b0, b1, e0, e1;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .si(si), .sen(sen), .sof(sof),
        .clr_err(clr_err), .q(q0), .valid(v0), .busy(b0), .err(e0)
    );

    sipo_rx #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .si(si), .sen(sen), .sof(sof),
        .clr_err(clr_err), .q(q1), .valid(v1), .busy(b1), .err(e1)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] expq0[$];
    logic [7:0] expq1[$];
    bit         frame[$];
    logic       m_busy, m_err, m_valid;
    logic [7:0] m_q0, m_q1;
    bit         run_mon = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        frame.delete();
        expq0.delete();
        expq1.delete();
        m_busy  = 1'b0;
        m_err   = 1'b0;
        m_valid = 1'b0;
        m_q0    = '0;
        m_q1    = '0;
    endfunction

    // Frame-level view: collect bits after a start marker, emit a word at 8.
    function automatic void model_edge();
        logic [7:0] w0, w1;
        m_valid = 1'b0;
        if (clr_err)
            m_err = 1'b0;
        if (sen) begin
            if (sof) begin
                if (m_busy)
                    m_err = 1'b1;
                frame.delete();
                frame.push_back(si);
                m_busy = 1'b1;
            end else if (m_busy) begin
                frame.push_back(si);
                if (frame.size() == 8) begin
                    for (int i = 0; i < 8; i++) begin
                        w0[i]     = frame[i];
                        w1[7 - i] = frame[i];
                    end
                    expq0.push_back(w0);
                    expq1.push_back(w1);
                    m_q0    = w0;
                    m_q1    = w1;
                    m_valid = 1'b1;
                    m_busy  = 1'b0;
                    frame.delete();
                end
            end
        end
    endfunction

    task automatic cyc(input bit en, input bit s, input bit d, input bit c = 1'b0);
        sen     = en;
        sof     = s;
        si      = d;
        clr_err = c;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(input logic [7:0] w, input int maxgap, input int nbits = 8);
        int g;
        for (int i = 0; i < nbits; i++) begin
            g = (i > 0 && maxgap > 0) ? $urandom_range(maxgap, 1) : 0;
            repeat (g) cyc(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            cyc(1'b1, i == 0, w[i]);
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check("rst_q_lsb", q0, 0);
        check("rst_q_msb", q1, 0);
        check("rst_valid", {v0, v1}, 0);
        check("rst_busy", {b0, b1}, 0);
        check("rst_err", {e0, e1}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (run_mon) begin
            check("valid_lsb", v0, m_valid);
            check("valid_msb", v1, m_valid);
            check("busy_lsb", b0, m_busy);
            check("busy_msb", b1, m_busy);
            check("err_lsb", e0, m_err);
            check("err_msb", e1, m_err);
            check("q_hold_lsb", q0, m_q0);
            check("q_hold_msb", q1, m_q1);
            if (v0) begin
                if (expq0.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_lsb: unexpected word %0h", q0);
                end else
                    check("sb_lsb", q0, expq0.pop_front());
            end
            if (v1) begin
                if (expq1.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_msb: unexpected word %0h", q1);
                end else
                    check("sb_msb", q1, expq1.pop_front());
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        sen     = 1'b0;
        sof     = 1'b0;
        si      = 1'b0;
        clr_err = 1'b0;
        model_clear();
        #1;
        check("por_q", {q0, q1}, 0);
        check("por_flags", {v0, b0, e0, v1, b1, e1}, 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        run_mon = 1'b1;

        send(8'hA5, 0);
        check("t2_q_lsb", q0, 8'hA5);
        check("t2_q_msb", q1, 8'hA5);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);

        send(8'hA5, 3);
        check("t3_q_lsb", q0, 8'hA5);

        send(8'h9B, 0, 4);
        send(8'h3C, 0);
        check("t4_err", e0, 1);
        check("t4_q_lsb", q0, 8'h3C);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_clr", e0, 0);

        send(8'hFF, 1, 5);
        do_reset();
        check("t5_q_after_rst", q0, 0);
        send(8'h0F, 0);
        check("t5_q_lsb", q0, 8'h0F);

        send(8'h12, 0);
        check("t6_q1_lsb", q0, 8'h12);
        check("t6_q1_msb", q1, 8'h48);
        send(8'hEF, 0);
        check("t6_q2_lsb", q0, 8'hEF);
        check("t6_q2_msb", q1, 8'hF7);

        send(8'h55, 0, 3);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check("err_set_wins", e0, 1);

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500)
                do_reset();
            cyc($urandom_range(9, 0) < 7, $urandom_range(11, 0) == 0,
                1'($urandom_range(1, 0)), $urandom_range(19, 0) == 0);
        end

        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        check("drain_lsb", expq0.size(), 0);
        check("drain_msb", expq1.size(), 0);
        run_mon = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
